// File: rtl/miniscope_pkg.sv
// rtl/miniscope_pkg.sv - shared types and widths for the miniscope frame logger.
package miniscope_pkg;

    localparam int TS_W    = 32;
    localparam int IDX_W   = 32;
    localparam int ENTRY_W = TS_W + IDX_W;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOG  = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] frame_idx;
        logic [TS_W-1:0]  timestamp;
    } log_entry_t;

endpackage

// File: rtl/frame_log_fifo.sv
// rtl/frame_log_fifo.sv - synchronous show-ahead FIFO of frame log entries.
module frame_log_fifo
    import miniscope_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  log_entry_t               push_data,
    input  logic                     pop,
    output log_entry_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    log_entry_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           pop_ok;
    logic           push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign level   = count;
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/miniscope_frame_logger.sv
// rtl/miniscope_frame_logger.sv - timestamps miniscope frame strobes into a log FIFO.
// Optional frame-gap timeout enabled by defining MINISCOPE_FRAME_TIMEOUT_EN.
module miniscope_frame_logger
    import miniscope_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          miniscope_sync,
    input  logic                          rd_en,
    output logic [ENTRY_W-1:0]            rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          timeout
);

    state_t             state;
    state_t             state_next;
    logic               logging;
    logic               session_start;
    logic               sync_s0;
    logic               sync_s1;
    logic               sync_s2;
    logic               frame_edge;
    logic               push;
    logic               full;
    logic               empty;
    logic [TS_W-1:0]    timestamp;
    logic [IDX_W-1:0]   frame_idx;
    log_entry_t         push_data;
    log_entry_t         head;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (enable)  state_next = S_LOG;
            S_LOG:   if (!enable) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        logging       = (state == S_LOG);
        session_start = (state == S_IDLE) && enable;
    end

    // sync_s0/s1 resynchronise the strobe; sync_s2 is the delayed copy for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_s0 <= 1'b0;
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
        end else begin
            sync_s0 <= miniscope_sync;
            sync_s1 <= sync_s0;
            sync_s2 <= sync_s1;
        end
    end

    assign frame_edge          = sync_s1 & ~sync_s2;
    assign push                = logging & frame_edge;
    assign push_data.frame_idx = frame_idx;
    assign push_data.timestamp = timestamp;

    always_ff @(posedge clk) begin
        if (reset || session_start) begin
            timestamp <= '0;
            frame_idx <= '0;
            overflow  <= 1'b0;
        end else if (logging) begin
            if (timestamp != '1) timestamp <= timestamp + TS_W'(1);
            // The index advances even for dropped frames so readers can see the hole.
            if (frame_edge)      frame_idx <= frame_idx + IDX_W'(1);
            if (push && full && !rd_en) overflow <= 1'b1;
        end
    end

`ifdef MINISCOPE_FRAME_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    logic [31:0] gap_cnt;
    logic        timeout_r;

    always_ff @(posedge clk) begin
        if (reset || session_start) begin
            gap_cnt   <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (gap_cnt >= TIMEOUT_LIM) timeout_r <= 1'b1;
            if (logging) begin
                if (frame_edge)          gap_cnt <= '0;
                else if (gap_cnt != '1)  gap_cnt <= gap_cnt + 32'd1;
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    frame_log_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (rd_en),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    assign rd_data  = head;
    assign rd_valid = ~empty;

endmodule

// File: tb/tb_miniscope_frame_logger.sv
// tb/tb_miniscope_frame_logger.sv - scoreboard bench for miniscope_frame_logger.
module tb_miniscope_frame_logger;
    import miniscope_pkg::*;

    localparam int D  = 16;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        miniscope_sync;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        timeout;

    miniscope_frame_logger #(
        .FIFO_DEPTH     (D),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .miniscope_sync (miniscope_sync),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit mon_on   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works from the sampled input history per clock edge.
    logic [63:0] exp_q[$];
    int          mcount = 0;
    int          cyc = 0;
    int          sess_start = 0;
    logic [31:0] m_idx = 0;
    bit          m_ovf = 0;
    int          m_gap = 0;
    bit          m_to = 0;
    bit          en_prev = 0;
    bit          s_h1 = 0, s_h2 = 0, s_h3 = 0;

    always @(posedge clk) begin
        bit in_log, start, frame, pop, push;
        logic [31:0] ts;
        cyc++;
        if (reset) begin
            exp_q.delete();
            mcount = 0; m_idx = 0; m_ovf = 0; m_gap = 0; m_to = 0;
            en_prev = 0; s_h1 = 0; s_h2 = 0; s_h3 = 0;
        end else begin
            in_log = en_prev;
            start  = enable && !in_log;
            frame  = s_h2 && !s_h3;
            pop    = rd_en && (mcount > 0);
            push   = frame && in_log;
            ts     = 32'(cyc - 1 - sess_start);
            if (start) begin
                sess_start = cyc;
                m_idx = 0; m_ovf = 0; m_gap = 0; m_to = 0;
            end else begin
                if (m_gap >= TO) m_to = 1;
                if (in_log) m_gap = frame ? 0 : m_gap + 1;
                if (push) begin
                    if (mcount == D && !pop) m_ovf = 1;
                    else begin
                        exp_q.push_back({m_idx, ts});
                        mcount++;
                    end
                    m_idx++;
                end
            end
            if (pop) mcount--;
            s_h3 = s_h2; s_h2 = s_h1; s_h1 = miniscope_sync;
            en_prev = enable;
        end
    end

    // Monitor: compares DUT outputs against the model between edges.
    always @(negedge clk) begin
        if (mon_on) begin
            check("level", fifo_level, 64'(mcount));
            check("rd_valid", rd_valid, (mcount > 0));
            check("overflow", overflow, m_ovf);
`ifdef MINISCOPE_FRAME_TIMEOUT_EN
            check("timeout", timeout, m_to);
`else
            check("timeout", timeout, 1'b0);
`endif
            if (exp_q.size() > 0) check("head_entry", rd_data, exp_q[0]);
            else                  check("empty_rd_data", rd_data, 64'd0);
            if (rd_en && mcount > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        miniscope_sync = 1'b1;
        tick(hi);
        miniscope_sync = 1'b0;
        tick(lo);
    endtask

    task automatic restart_session();
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t0;
        reset = 1'b1; enable = 1'b0; miniscope_sync = 1'b0; rd_en = 1'b0;
        tick(1);
        mon_on = 1;
        tick(2);
        check("reset_level", fifo_level, 0);
        check("reset_rd_valid", rd_valid, 0);
        reset = 1'b0;

        // Three frames 100 cycles apart.
        enable = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) pulse(3, 97);
        check("req032_level", fifo_level, 3);
        t0 = rd_data[31:0];
        for (int i = 0; i < 3; i++) begin
            check("req032_idx", rd_data[63:32], 64'(i));
            check("req032_ts", rd_data[31:0], 64'(t0 + 32'(100 * i)));
            rd_en = 1'b1;
            tick(1);
        end
        rd_en = 1'b0;
        tick(2);

        // Overflow with 18 frames into a 16-deep log.
        restart_session();
        for (int i = 0; i < 18; i++) pulse(2, 3);
        tick(4);
        check("req033_level", fifo_level, 16);
        check("req033_overflow", overflow, 1);
        rd_en = 1'b1; tick(20); rd_en = 1'b0;
        pulse(2, 4);
        check("req033_next_idx", rd_data[63:32], 18);
        rd_en = 1'b1; tick(2); rd_en = 1'b0;

        // Full FIFO, push coincides with pop.
        restart_session();
        for (int i = 0; i < 16; i++) pulse(2, 3);
        tick(4);
        check("req034_full", fifo_level, 16);
        miniscope_sync = 1'b1;
        tick(2);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("req034_level", fifo_level, 16);
        check("req034_overflow", overflow, 0);
        miniscope_sync = 1'b0;
        tick(3);
        rd_en = 1'b1; tick(18); rd_en = 1'b0;

        // Frames outside the logging window are ignored; the new session restarts counters.
        enable = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) pulse(3, 3);
        check("req035_no_push", fifo_level, 0);
        enable = 1'b1;
        tick(1);
        miniscope_sync = 1'b1;
        tick(3);
        check("req035_first_entry", rd_data, 64'h0000_0000_0000_0002);
        miniscope_sync = 1'b0;
        tick(3);
        rd_en = 1'b1; tick(2); rd_en = 1'b0;

        // Frame gap of 60 cycles.
        restart_session();
        pulse(2, 60);
        pulse(2, 3);
`ifdef MINISCOPE_FRAME_TIMEOUT_EN
        check("req036_timeout", timeout, 1);
`else
        check("req036_timeout", timeout, 0);
`endif
        pulse(2, 3);
        pulse(2, 3);
`ifdef MINISCOPE_FRAME_TIMEOUT_EN
        check("req036_sticky", timeout, 1);
`else
        check("req036_sticky", timeout, 0);
`endif
        rd_en = 1'b1; tick(6); rd_en = 1'b0;

        // Randomised traffic including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if ($urandom_range(0, 3) == 0) miniscope_sync = ~miniscope_sync;
            rd_en = ($urandom_range(0, 2) == 0);
            tick(1);
        end
        reset = 1'b0; rd_en = 1'b0; miniscope_sync = 1'b0;

        // Reset mid-session with five entries held.
        reset = 1'b1; tick(1); reset = 1'b0;
        enable = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++) pulse(2, 3);
        check("req037_before", fifo_level, 5);
        reset = 1'b1;
        rd_en = 1'b1;
        miniscope_sync = 1'b1;
        tick(1);
        check("req037_level", fifo_level, 0);
        check("req037_rd_valid", rd_valid, 0);
        check("req037_state", dut.state, S_IDLE);
        reset = 1'b0; rd_en = 1'b0; miniscope_sync = 1'b0;
        tick(5);

        mon_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
